// File: rtl/sha256_round_engine_if.sv
// Handshake and data bundle between the SHA-256 round engine and its owner.
// The owner also sources the K word, combinationally, from k_addr.
interface sha256_round_engine_if;
  logic         start;
  logic [255:0] state_in;
  logic [511:0] block_in;
  logic [5:0]   k_addr;
  logic [31:0]  k;
  logic         busy;
  logic         done;
  logic [255:0] digest_out;

  modport master (output start, state_in, block_in, k,
                  input  k_addr, busy, done, digest_out);
  modport slave  (input  start, state_in, block_in, k,
                  output k_addr, busy, done, digest_out);
endinterface

// File: rtl/sha256_round_engine.sv
// Single-block SHA-256 compression: one round per clock, K fetched from an
// external ROM through k_addr in the same cycle it is consumed.
module sha256_round_engine #(
  parameter int ROUNDS = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  sha256_round_engine_if.slave   bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, FINAL = 2'd2} state_t;

  localparam logic [5:0] LAST = 6'(ROUNDS - 1);

  state_t             state, state_nxt;
  logic [5:0]         round;
  logic [7:0][31:0]   hv;
  logic [7:0][31:0]   wv, wv_nxt;
  logic [15:0][31:0]  sched;
  logic [31:0]        w_new, t1, t2;
  logic [255:0]       digest_q, dig_nxt;
  logic               busy_q, done_q;
  logic               accept, last;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bs0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bs1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        accept    = 1'b1;
        state_nxt = ROUND;
      end
      ROUND: if (round == LAST) begin
        last      = 1'b1;
        state_nxt = FINAL;
      end
      FINAL:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The schedule window holds W[t..t+15], so W[t+16] is computed one step
  // ahead and sched[0] is always the word for the current round.
  always_comb begin
    w_new  = ss1(sched[14]) + sched[9] + ss0(sched[1]) + sched[0];
    t1     = wv[7] + bs1(wv[4]) + ((wv[4] & wv[5]) ^ (~wv[4] & wv[6]))
             + bus.k + sched[0];
    t2     = bs0(wv[0]) + ((wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]));
    wv_nxt = {wv[6:4], wv[3] + t1, wv[2:0], t1 + t2};
    dig_nxt = '0;
    for (int i = 0; i < 8; i++) dig_nxt[32*(7-i) +: 32] = hv[i] + wv[i];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      round    <= '0;
      hv       <= '0;
      wv       <= '0;
      sched    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      digest_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        round  <= '0;
        busy_q <= 1'b1;
        for (int i = 0; i < 8; i++) begin
          hv[i] <= bus.state_in[32*(7-i) +: 32];
          wv[i] <= bus.state_in[32*(7-i) +: 32];
        end
        for (int i = 0; i < 16; i++) sched[i] <= bus.block_in[32*(15-i) +: 32];
      end else if (state == ROUND) begin
        round <= last ? 6'd0 : round + 6'd1;
        wv    <= wv_nxt;
        sched <= {w_new, sched[15:1]};
      end else if (state == FINAL) begin
        digest_q <= dig_nxt;
        done_q   <= 1'b1;
        busy_q   <= 1'b0;
      end
    end
  end

  // round is held at zero outside ROUND, so it doubles as the ROM address.
  assign bus.k_addr     = round;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.digest_out = digest_q;
endmodule

// File: tb/tb_sha256_round_engine.sv
// Directed and random checks of sha256_round_engine against known digests
// and an array-based SHA-256 compression model.
module tb_sha256_round_engine;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [255:0] IV      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] BLK_E   = {32'h80000000, 480'd0};
  localparam logic [511:0] BLK_ABC = {32'h61626380, 448'd0, 32'h00000018};
  localparam logic [255:0] DIG_E   = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  sha256_round_engine_if bus();

  sha256_round_engine #(.ROUNDS(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.k = KT[bus.k_addr];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook compression: full 64-word message expansion, then 64 rounds.
  function automatic logic [255:0] ref_hash(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, x1, x2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    a = h[255:224]; b = h[223:192]; c = h[191:160]; d = h[159:128];
    e = h[127:96];  f = h[95:64];   g = h[63:32];   hh = h[31:0];
    for (int t = 0; t < 64; t++) begin
      x1 = hh + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
      x2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + x1; d = c; c = b; b = a; a = x1 + x2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e,  h[95:64] + f,   h[63:32] + g,   h[31:0] + hh};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand_blk();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // Called #1 after an edge; start is sampled on the following edge.
  task automatic launch(input logic [255:0] s, input logic [511:0] b);
    bus.state_in = s;
    bus.block_in = b;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.state_in = {rand_blk(), rand_blk()} >> 512;
    bus.block_in = rand_blk();
  endtask

  // n counts edges after the accepting edge; done is expected at n == 65.
  task automatic run_wait(input int inject_at, input int abort_at, output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 200) begin
      chk("k_addr", bus.k_addr, (n < 64) ? n : 0);
      chk("busy_run", bus.busy, 1);
      if (n == inject_at) begin
        bus.start    = 1'b1;
        bus.block_in = rand_blk();
      end
      if (n == abort_at) begin
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        return;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      n++;
    end
    chk("latency", n, 65);
    chk("busy_done", bus.busy, 0);
  endtask

  initial begin
    int n, t_first, dc0;
    logic [255:0] s;
    logic [511:0] b;

    rst = 1'b0;
    bus.start = 1'b0;
    bus.state_in = '0;
    bus.block_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_kaddr", bus.k_addr, 0);
    chk("rst_digest", bus.digest_out, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // empty message
    launch(IV, BLK_E);
    run_wait(-1, -1, n);
    chk("empty_digest", bus.digest_out, DIG_E);
    @(posedge clk); #1;
    chk("done_pulse", bus.done, 0);
    chk("digest_held", bus.digest_out, DIG_E);

    // "abc"
    launch(IV, BLK_ABC);
    run_wait(-1, -1, n);
    chk("abc_digest", bus.digest_out, DIG_ABC);
    repeat (3) @(posedge clk);
    #1;

    // start re-pulsed mid-block must be ignored
    launch(IV, BLK_ABC);
    run_wait(10, -1, n);
    chk("ignore_start_digest", bus.digest_out, DIG_ABC);
    @(posedge clk); #1;
    chk("no_queued_start", bus.busy, 0);

    // back-to-back: second start in the done cycle
    launch(IV, BLK_ABC);
    run_wait(-1, -1, n);
    t_first = cyc;
    chk("b2b_first", bus.digest_out, DIG_ABC);
    launch(IV, BLK_E);
    run_wait(-1, -1, n);
    chk("b2b_gap", cyc - t_first, 66);
    chk("b2b_second", bus.digest_out, DIG_E);
    @(posedge clk); #1;

    // reset mid-block
    launch(IV, BLK_E);
    run_wait(-1, 30, n);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_kaddr", bus.k_addr, 0);
    chk("abort_digest", bus.digest_out, 0);
    dc0 = done_cnt;
    repeat (80) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, dc0);
    launch(IV, BLK_E);
    run_wait(-1, -1, n);
    chk("after_abort_digest", bus.digest_out, DIG_E);

    // random chaining values and blocks, alternating gap / back-to-back
    for (int i = 0; i < 6; i++) begin
      s = {rand_blk(), rand_blk()} >> 512;
      b = rand_blk();
      if (i[0]) begin
        @(posedge clk); #1;
      end
      launch(s, b);
      run_wait(-1, -1, n);
      chk("rand_digest", bus.digest_out, ref_hash(s, b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
